// File: rtl/draw_mux_pkg.sv
// rtl/draw_mux_pkg.sv - shared types and helpers for objects_draw_mux
package draw_mux_pkg;

  typedef logic [7:0] rgb_t;

  localparam int         MAX_OBJ   = 8;
  localparam logic [7:0] COUNT_MAX = 8'd255;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } mux_state_t;

  // True when two or more objects request the same pixel.
  function automatic logic multi_req(input logic [MAX_OBJ-1:0] req);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < MAX_OBJ; i++) begin
      n = n + {3'b000, req[i]};
    end
    return n >= 4'd2;
  endfunction

endpackage

// File: rtl/collision_accum.sv
// rtl/collision_accum.sv - per-pixel collision detect and per-frame collision summary
module collision_accum
  import draw_mux_pkg::*;
#(
  parameter int NUM_OBJ = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [NUM_OBJ-1:0] drawReq,
  output logic               collision,
  output logic [NUM_OBJ-1:0] frameMask,
  output logic [7:0]         frameCount,
  output logic               frameValid
);

  mux_state_t         state_q, state_d;
  logic [NUM_OBJ-1:0] acc_mask_q, acc_mask_d;
  logic [7:0]         acc_count_q, acc_count_d;
  logic [NUM_OBJ-1:0] frame_mask_q, frame_mask_d;
  logic [7:0]         frame_count_q, frame_count_d;
  logic               frame_valid_q, frame_valid_d;
  logic               collision_q;
  logic               collide;

  assign collide = multi_req(MAX_OBJ'(drawReq));

  always_comb begin
    state_d       = state_q;
    acc_mask_d    = acc_mask_q;
    acc_count_d   = acc_count_q;
    frame_mask_d  = frame_mask_q;
    frame_count_d = frame_count_q;
    frame_valid_d = frame_valid_q;
    if (startOfFrame) begin
      // The SOF pixel opens the new frame, so it seeds the accumulators.
      acc_mask_d  = collide ? drawReq : '0;
      acc_count_d = collide ? 8'd1 : 8'd0;
      state_d     = RUN;
      if (state_q == RUN) begin
        frame_mask_d  = acc_mask_q;
        frame_count_d = acc_count_q;
        frame_valid_d = 1'b1;
      end
    end else if (collide) begin
      acc_mask_d = acc_mask_q | drawReq;
      if (acc_count_q != COUNT_MAX) begin
        acc_count_d = acc_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= WAIT_SOF;
      acc_mask_q    <= '0;
      acc_count_q   <= 8'd0;
      frame_mask_q  <= '0;
      frame_count_q <= 8'd0;
      frame_valid_q <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_mask_q    <= acc_mask_d;
      acc_count_q   <= acc_count_d;
      frame_mask_q  <= frame_mask_d;
      frame_count_q <= frame_count_d;
      frame_valid_q <= frame_valid_d;
      collision_q   <= collide;
    end
  end

  assign collision  = collision_q;
  assign frameMask  = frame_mask_q;
  assign frameCount = frame_count_q;
  assign frameValid = frame_valid_q;

endmodule

// File: rtl/objects_draw_mux.sv
// rtl/objects_draw_mux.sv - priority pixel colour mux; collision summary under DRAW_MUX_COLLISION_EN
module objects_draw_mux
  import draw_mux_pkg::*;
#(
  parameter int   NUM_OBJ  = 4,
  parameter rgb_t BG_COLOR = 8'h00
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUM_OBJ-1:0]      drawReq,
  input  logic [NUM_OBJ-1:0][7:0] rgbIn,
  output rgb_t                    RGBout,
  output logic                    collision,
  output logic [NUM_OBJ-1:0]      frameMask,
  output logic [7:0]              frameCount,
  output logic                    frameValid
);

  rgb_t rgb_q, rgb_d;

  // Scan from the top so the lowest requesting index is the last write.
  always_comb begin
    rgb_d = BG_COLOR;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (drawReq[i]) begin
        rgb_d = rgbIn[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q <= BG_COLOR;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign RGBout = rgb_q;

`ifdef DRAW_MUX_COLLISION_EN
  collision_accum #(
    .NUM_OBJ (NUM_OBJ)
  ) u_collision_accum (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .drawReq      (drawReq),
    .collision    (collision),
    .frameMask    (frameMask),
    .frameCount   (frameCount),
    .frameValid   (frameValid)
  );
`else
  logic unused_sof;
  assign unused_sof = startOfFrame;
  assign collision  = 1'b0;
  assign frameMask  = '0;
  assign frameCount = 8'd0;
  assign frameValid = 1'b0;
`endif

endmodule

// File: tb/tb_objects_draw_mux.sv
// tb/tb_objects_draw_mux.sv - scoreboard bench for objects_draw_mux
module tb_objects_draw_mux;

  localparam int         N  = 4;
  localparam logic [7:0] BG = 8'h00;
`ifdef DRAW_MUX_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic [N-1:0]      drawReq;
  logic [N-1:0][7:0] rgbIn;
  logic [7:0]        RGBout;
  logic              collision;
  logic [N-1:0]      frameMask;
  logic [7:0]        frameCount;
  logic              frameValid;

  objects_draw_mux #(
    .NUM_OBJ  (N),
    .BG_COLOR (BG)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .drawReq      (drawReq),
    .rgbIn        (rgbIn),
    .RGBout       (RGBout),
    .collision    (collision),
    .frameMask    (frameMask),
    .frameCount   (frameCount),
    .frameValid   (frameValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   rgb;
    logic         coll;
    logic [N-1:0] fmask;
    logic [7:0]   fcnt;
    logic         fvalid;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference frame model: the frame in progress is a set of objects plus an
  // unbounded collision tally; saturation is applied only when published.
  bit           m_run;
  logic [N-1:0] m_cur_objs;
  int           m_cur_hits;
  logic [N-1:0] m_pub_objs;
  int           m_pub_hits;
  bit           m_pub_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst_n, input bit sof, input logic [N-1:0] req,
                       input logic [N-1:0][7:0] rgb_val);
    exp_t e;
    bit   hit;
    @(negedge clk);
    resetN       = rst_n;
    startOfFrame = sof;
    drawReq      = req;
    rgbIn        = rgb_val;
    hit          = ($countones(req) >= 2);
    e.rgb        = BG;
    e.coll       = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_cur_objs = '0; m_cur_hits = 0;
      m_pub_objs = '0; m_pub_hits = 0; m_pub_valid = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          e.rgb = rgb_val[i];
          break;
        end
      end
      e.coll = hit;
      if (sof) begin
        if (m_run) begin
          m_pub_objs  = m_cur_objs;
          m_pub_hits  = (m_cur_hits > 255) ? 255 : m_cur_hits;
          m_pub_valid = 1;
        end
        m_run      = 1;
        m_cur_objs = hit ? req : '0;
        m_cur_hits = hit ? 1 : 0;
      end else if (hit) begin
        m_cur_objs = m_cur_objs | req;
        m_cur_hits = m_cur_hits + 1;
      end
    end
    e.coll   = COLL_EN ? e.coll : 1'b0;
    e.fmask  = COLL_EN ? m_pub_objs : '0;
    e.fcnt   = COLL_EN ? 8'(m_pub_hits) : 8'd0;
    e.fvalid = COLL_EN ? m_pub_valid : 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic pix(input bit sof, input logic [N-1:0] req);
    logic [N-1:0][7:0] v;
    for (int i = 0; i < N; i++) v[i] = 8'($urandom);
    drive(1'b1, sof, req, v);
  endtask

  task automatic frame_check(input string tag, input logic [N-1:0] mask,
                             input logic [7:0] cnt, input bit valid);
    @(posedge clk);
    #1;
    check({tag, "_mask"},  32'(frameMask),  COLL_EN ? 32'(mask) : 32'd0);
    check({tag, "_count"}, 32'(frameCount), COLL_EN ? 32'(cnt) : 32'd0);
    check({tag, "_valid"}, 32'(frameValid), COLL_EN ? 32'(valid) : 32'd0);
  endtask

  // Monitor: the output visible just after each edge answers the oldest push.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rgb",         32'(RGBout),     32'(e.rgb));
        check("collision",   32'(collision),  32'(e.coll));
        check("frame_mask",  32'(frameMask),  32'(e.fmask));
        check("frame_count", 32'(frameCount), 32'(e.fcnt));
        check("frame_valid", 32'(frameValid), 32'(e.fvalid));
      end
    end
  end

  initial begin
    logic [N-1:0][7:0] v;
    int sof_cnt;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    drawReq      = '0;
    rgbIn        = '0;
    v            = '0;

    repeat (3) drive(1'b0, 1'b0, '0, v);
    @(posedge clk);
    #1;
    check("reset_rgb",   32'(RGBout),     32'(BG));
    check("reset_coll",  32'(collision),  32'd0);
    check("reset_valid", 32'(frameValid), 32'd0);
    repeat (2) pix(1'b0, '0);

    v    = '0;
    v[0] = 8'h55; v[1] = 8'hc4; v[2] = 8'h1f; v[3] = 8'h77;
    drive(1'b1, 1'b0, 4'b0110, v);
    @(posedge clk);
    #1;
    check("pair_rgb",  32'(RGBout),    32'h0000_00c4);
    check("pair_coll", 32'(collision), COLL_EN ? 32'd1 : 32'd0);

    pix(1'b1, 4'b0000);
    pix(1'b0, 4'b0011);
    pix(1'b0, 4'b0011);
    pix(1'b0, 4'b1001);
    pix(1'b1, 4'b0000);
    frame_check("frame_pass", 4'b1011, 8'd3, 1'b1);

    repeat (300) pix(1'b0, 4'b1111);
    pix(1'b1, 4'b0000);
    frame_check("saturate", 4'b1111, 8'd255, 1'b1);

    pix(1'b0, 4'b0011);
    pix(1'b0, 4'b0011);
    pix(1'b1, 4'b0101);
    frame_check("sof_pixel_excluded", 4'b0011, 8'd2, 1'b1);
    repeat (3) pix(1'b0, 4'b0000);
    pix(1'b1, 4'b0000);
    frame_check("sof_pixel_included", 4'b0101, 8'd1, 1'b1);

    repeat (5) pix(1'b0, 4'b1100);
    drive(1'b0, 1'b0, '0, v);
    frame_check("mid_reset", 4'b0000, 8'd0, 1'b0);
    drive(1'b0, 1'b0, '0, v);
    pix(1'b1, 4'b0000);
    pix(1'b0, 4'b0001);
    pix(1'b0, 4'b0010);
    pix(1'b0, 4'b0100);
    pix(1'b1, 4'b0000);
    frame_check("after_reset", 4'b0000, 8'd0, 1'b1);

    sof_cnt = $urandom_range(5, 40);
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] req;
      bit           sof;
      sof = (sof_cnt == 0) || ($urandom_range(0, 199) == 0);
      sof_cnt = sof ? $urandom_range(1, 40) : sof_cnt - 1;
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = N'(1 << $urandom_range(0, N - 1));
        default: req = N'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) drive(1'b0, 1'b0, req, v);
      else                              pix(sof, req);
    end

    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/objects_draw_mux.md
# objects_draw_mux

Consumer end of the object-drawing interface: it collects `drawingRequest`/`RGBout` pairs from up to `NUM_OBJ` bitmap objects, selects one pixel colour by fixed priority, and drives a single registered 8-bit colour toward the VGA output stage. It also detects collisions, meaning pixels where two or more objects request drawing at once. Collisions are reported per pixel and summarised per frame for the game-logic controller.

## Interface
Parameters:
- `NUM_OBJ`, 4, number of object inputs (2..8).
- `BG_COLOR`, 8'h00, colour driven when no object requests.

Ports:
- `clk`  in  1  pixel clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse aligned with the first pixel of a frame.
- `drawReq`  in  NUM_OBJ  per-object drawing requests; bit 0 has the highest priority.
- `rgbIn`  in  NUM_OBJ×8  packed per-object colours; `rgbIn[i]` pairs with `drawReq[i]`.
- `RGBout`  out  8  selected pixel colour.
- `collision`  out  1  pixel-level collision pulse.
- `frameMask`  out  NUM_OBJ  objects involved in any collision during the last completed frame.
- `frameCount`  out  8  collision pixels in the last completed frame, saturating.
- `frameValid`  out  1  high once `frameMask`/`frameCount` describe a completed frame.

## Operation
- Colour select: the lowest index `i` with `drawReq[i]=1` wins, and `rgbIn[i]` is registered to `RGBout`. If no bit is set, `BG_COLOR` is registered.
- Pixel collision: the number of set `drawReq` bits is ≥ 2 → `collision`=1 on the next cycle, otherwise 0.
- Accumulators:
  - `accMask |= drawReq` on each collision cycle.
  - `accCount` increments on each collision cycle and saturates at 255; it holds there and never wraps.
- State machine:
  - WAIT_SOF (reset state) → RUN on the first `startOfFrame`.
  - RUN stays in RUN. Each `startOfFrame` while in RUN ends a frame.
- Frame end (a `startOfFrame` cycle while in RUN):
  - `frameMask <= accMask` and `frameCount <= accCount`, with `frameValid <= 1`.
  - The accumulators restart with this cycle's contribution only: `accMask <= collide ? drawReq : 0` and `accCount <= collide ? 1 : 0`. The SOF pixel belongs to the new frame.
- `startOfFrame` in WAIT_SOF:
  - The accumulators load this cycle's contribution, as above.
  - `frameMask`, `frameCount` and `frameValid` do not change.
- In WAIT_SOF the accumulators still update, but the values are discarded at the first SOF.
- `frameMask`/`frameCount` hold steady for a whole frame; they change only at a frame end.
- Reset, including mid-frame:
  - All outputs return to their reset values: `RGBout`=BG_COLOR, `collision`=0, `frameMask`=0, `frameCount`=0, `frameValid`=0.
  - Accumulators clear to 0 and the state machine returns to WAIT_SOF.

## Timing
- Latency: 1 clock from `drawReq`/`rgbIn` to `RGBout` and to `collision`. No combinational path runs from inputs to outputs.
- Frame summary outputs update on the clock edge that samples `startOfFrame` in RUN, and are visible the cycle after the SOF pulse.
- There is no handshake. Inputs are sampled every cycle, and a throughput of 1 pixel per clock is mandatory.
- Back-to-back `startOfFrame` pulses are legal. The second pulse publishes a frame containing only the first pulse's contribution.

## Configuration
- `DRAW_MUX_COLLISION_EN` defined: full collision logic, accumulators and state machine, as specified above.
- Not defined: only the priority colour select is built. `collision`, `frameMask`, `frameCount` and `frameValid` are tied to 0, and no accumulator or FSM flops are synthesised. `RGBout` timing is unchanged.

## Structure
- Package `draw_mux_pkg`:
  - `rgb_t` (8-bit colour typedef).
  - `MAX_OBJ` = 8.
  - `COUNT_MAX` = 8'd255.
  - FSM enum `mux_state_t` {WAIT_SOF, RUN}.
- Sub-module `collision_accum`:
  - Contains the popcount ≥ 2 detection, `accMask`/`accCount`, the FSM and the frame registers.
  - Instantiated only under `DRAW_MUX_COLLISION_EN`.
- The top level keeps the priority encoder and the `RGBout` register.

## Test plan
- Reset, then `drawReq`=0 → `RGBout`=8'h00, `collision`=0, `frameValid`=0.
- `drawReq`=4'b0110 with `rgbIn[1]`=8'hc4 and `rgbIn[2]`=8'h1f → `RGBout`=8'hc4 and `collision`=1, both one cycle later.
- Frame pass:
  - Stimulus: SOF; 3 collision pixels with masks 0011, 0011, 1001; then SOF.
  - Response after the second SOF: `frameMask`=4'b1011, `frameCount`=3, `frameValid`=1.
- Saturation: 300 collision pixels between two SOFs → `frameCount`=255.
- SOF coinciding with `drawReq`=0101:
  - The previous frame is published without this pixel.
  - At the next SOF, the published `frameMask` includes 0101 and `frameCount` ≥ 1.
- Reset mid-frame after 5 collisions, then SOF, 0 collisions, SOF → `frameValid` goes to 0 at reset and after the second SOF `frameCount`=0.
